fp_div: RTL and testbench

//  Sequential IEEE-754 single-precision divider, R = A / B. Companion to the FPU
//  add/sub/mult path: same start/done handshake and hidden-bit + guard/sticky datapath.

---
 rtl/fp_div.sv | 205 ++++++++++++++++++++
 tb/tb_fp_div.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fp_div.sv
// Sequential IEEE-754 single-precision divider (R = A / B).
// Restoring mantissa division, one quotient bit per clock, round to nearest even.
module fp_div #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned FRAC_W = 23,
  parameter int unsigned BIAS   = 127
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [EXP_W+FRAC_W:0]     A,
  input  logic [EXP_W+FRAC_W:0]     B,
  input  logic                      start,
  output logic [EXP_W+FRAC_W:0]     R,
  output logic                      done,
  output logic                      div_by_zero,
  output logic                      overflow
);

  localparam int unsigned W       = 1 + EXP_W + FRAC_W;
  localparam int unsigned MW      = FRAC_W + 1;
  localparam int unsigned QW      = MW + 2;
  localparam int unsigned EW      = EXP_W + 2;
  localparam int unsigned CW      = $clog2(QW);
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W - 1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StDivide,
    StNorm,
    StRound,
    StDone
  } state_t;

  state_t state_q, state_d;

  logic [W-1:0]          a_q, b_q;
  logic                  sign_q;
  logic signed [EW-1:0]  exp_q;
  logic [MW-1:0]         mb_q;
  logic [MW:0]           rem_q;
  logic [QW-1:0]         quo_q;
  logic [CW-1:0]         cnt_q;
  logic [MW-1:0]         mant_q;
  logic                  guard_q, sticky_q;
  logic [W-1:0]          r_q;
  logic                  done_q, dbz_q, ovf_q;

  // Operand classification from the captured operands
  logic [EXP_W-1:0]  a_exp, b_exp;
  logic [FRAC_W-1:0] a_frac, b_frac;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_exp  = a_q[W-2 -: EXP_W];
  assign b_exp  = b_q[W-2 -: EXP_W];
  assign a_frac = a_q[FRAC_W-1:0];
  assign b_frac = b_q[FRAC_W-1:0];
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == '1) && (a_frac == '0);
  assign b_inf  = (b_exp == '1) && (b_frac == '0);
  assign a_nan  = (a_exp == '1) && (a_frac != '0);
  assign b_nan  = (b_exp == '1) && (b_frac != '0);

  // One restoring-division step
  logic          q_bit;
  logic [MW:0]   rem_sub;

  always_comb begin
    q_bit   = (rem_q >= {1'b0, mb_q});
    rem_sub = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;
  end

  // Rounding and result packing
  logic                 inc;
  logic [MW:0]          mant_sum;
  logic [FRAC_W-1:0]    frac_rnd;
  logic signed [EW-1:0] e_rnd;
  logic [W-1:0]         inf_r, zero_r, res_r;
  logic                 res_dbz, res_ovf;

  always_comb begin
    inc      = guard_q & (sticky_q | mant_q[0]);
    mant_sum = {1'b0, mant_q} + {{MW{1'b0}}, inc};
    if (mant_sum[MW]) begin
      frac_rnd = mant_sum[FRAC_W:1];
      e_rnd    = exp_q + EW'(1);
    end else begin
      frac_rnd = mant_sum[FRAC_W-1:0];
      e_rnd    = exp_q;
    end

    inf_r   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    zero_r  = {sign_q, {(W - 1){1'b0}}};
    res_r   = {sign_q, e_rnd[EXP_W-1:0], frac_rnd};
    res_dbz = 1'b0;
    res_ovf = 1'b0;

    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      res_r = QNAN;
    end else if (a_inf || b_zero) begin
      res_r   = inf_r;
      res_dbz = b_zero && !a_inf;
    end else if (a_zero || b_inf) begin
      res_r = zero_r;
    end else if (e_rnd >= $signed(EW'(EXP_MAX))) begin
      res_r   = inf_r;
      res_ovf = 1'b1;
    end else if (e_rnd <= $signed(EW'(0))) begin
      res_r = zero_r;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StUnpack;
      StUnpack:       state_d = StDivide;
      StDivide:       if (cnt_q == CW'(QW - 1)) state_d = StNorm;
      StNorm:         state_d = StRound;
      StRound:        state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      // done follows the first full cycle spent in DONE
      done_q  <= (state_q == StDone) && (state_d == StDone);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mb_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      r_q      <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            dbz_q <= 1'b0;
            ovf_q <= 1'b0;
          end
        end
        StUnpack: begin
          sign_q <= a_q[W-1] ^ b_q[W-1];
          exp_q  <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + $signed(EW'(BIAS));
          rem_q  <= {2'b01, a_frac};
          mb_q   <= {1'b1, b_frac};
          quo_q  <= '0;
          cnt_q  <= '0;
        end
        StDivide: begin
          rem_q <= rem_sub << 1;
          quo_q <= {quo_q[QW-2:0], q_bit};
          cnt_q <= cnt_q + CW'(1);
        end
        StNorm: begin
          if (quo_q[QW-1]) begin
            mant_q   <= quo_q[QW-1:2];
            guard_q  <= quo_q[1];
            sticky_q <= quo_q[0] | (rem_q != '0);
          end else begin
            mant_q   <= quo_q[QW-2:1];
            guard_q  <= quo_q[0];
            sticky_q <= (rem_q != '0);
            exp_q    <= exp_q - EW'(1);
          end
        end
        StRound: begin
          r_q   <= res_r;
          dbz_q <= res_dbz;
          ovf_q <= res_ovf;
        end
        default: ;
      endcase
    end
  end

  assign R           = r_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fp_div.sv
// Directed bench for fp_div: scoreboard of expected results, latency and handshake checks.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B, R;
  logic        start, done, div_by_zero, overflow;

  fp_div dut (
    .clk         (clk),
    .rst         (rst),
    .A           (A),
    .B           (B),
    .start       (start),
    .R           (R),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  // Drive one start; returns 1 ns after the accepting edge
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                        input logic dbz, input logic ovf);
    exp_t e;
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    e     = '{r: r, dbz: dbz, ovf: ovf};
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Wait (bounded) for done, then check latency and pop the scoreboard
  task automatic collect(input string tag, input int elapsed);
    int   n;
    exp_t e;
    n = elapsed;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, n, 30);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed R %h, expected an entry", tag, R);
    end else begin
      e = sb.pop_front();
      check({tag, " R"}, R, e.r);
      check({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, e.dbz});
      check({tag, " overflow"}, {31'b0, overflow}, {31'b0, e.ovf});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset R", R, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset div_by_zero", {31'b0, div_by_zero}, 32'h0);
    check("reset overflow", {31'b0, overflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    launch(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0); collect("6/2", 0);
    launch(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0); collect("1/3", 0);
    launch(32'hC0F00000, 32'h40200000, 32'hC0400000, 1'b0, 1'b0); collect("-7.5/2.5", 0);
    launch(32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0); collect("1/0", 0);
    launch(32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b0); collect("0/0", 0);
    launch(32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b1); collect("ovf", 0);
    launch(32'h00800000, 32'h4B000000, 32'h00000000, 1'b0, 1'b0); collect("underflow", 0);
    launch(32'h40400000, 32'h40000000, 32'h3FC00000, 1'b0, 1'b0); collect("3/2", 0);
    launch(32'hBF800000, 32'hC0000000, 32'h3F000000, 1'b0, 1'b0); collect("-1/-2", 0);
    launch(32'h7F800000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0); collect("inf/2", 0);
    launch(32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0); collect("-0/1", 0);
    launch(32'h40000000, 32'h7F800000, 32'h00000000, 1'b0, 1'b0); collect("2/inf", 0);
    launch(32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0); collect("nan/1", 0);
    launch(32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b0); collect("inf/inf", 0);
    launch(32'hBF800000, 32'h00000000, 32'hFF800000, 1'b1, 1'b0); collect("-1/0", 0);
    launch(32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0); collect("e=0", 0);
    launch(32'h01000000, 32'h40000000, 32'h00800000, 1'b0, 1'b0); collect("e=1", 0);
    launch(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 1'b0, 1'b0); collect("e=254", 0);
    launch(32'h7F7FFFFF, 32'h3F7FFFFF, 32'h7F800000, 1'b0, 1'b1); collect("e=255", 0);

    // Start pulsed mid-DIVIDE with new operands must be ignored
    launch(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    A     = 32'h3F800000;
    B     = 32'h40400000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    collect("ignored start", 7);

    // Back-to-back: start accepted in DONE drops done, R holds old value
    launch(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, 1'b0);
    check("b2b done low", {31'b0, done}, 32'h0);
    check("b2b R held", R, 32'h40400000);
    collect("b2b", 0);

    // Reset during DIVIDE aborts the operation
    launch(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort done", {31'b0, done}, 32'h0);
    check("abort R", R, 32'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort no result done", {31'b0, done}, 32'h0);
    check("abort no result R", R, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
